// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the fetch unit.
// FSM encoding, default geometry and the flush padding helper.
package prog_loader_pkg;

  localparam int DEF_ADDR_W         = 14;
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // The assembly register holds n received bytes right-aligned; move them to
  // the top of the word and zero the missing low bytes.
  function automatic logic [31:0] pad_word(input logic [31:0] asm_word,
                                           input logic [1:0]  n_bytes);
    case (n_bytes)
      2'd1:    return {asm_word[7:0], 24'h0};
      2'd2:    return {asm_word[15:0], 16'h0};
      2'd3:    return {asm_word[23:0], 8'h0};
      default: return asm_word;
    endcase
  endfunction

endpackage

// File: rtl/prog_loader_idle_timer.sv
// Idle timer for the program loader: counts cycles while enabled and pulses
// expire_o when the count reaches TIMEOUT_CYCLES-1 without a clear.
module idle_timer
  import prog_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;
  logic          at_term;

  assign at_term  = (count_q == TERM);
  assign expire_o = enable_i && !clear_i && at_term;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = at_term ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) count_q <= '0;
    else           count_q <= count_d;
  end

endmodule

// File: rtl/prog_loader.sv
// Program-memory writer: assembles big-endian words from the UART byte stream
// and writes them to instruction memory while holding the CPU in reset.
// Optional running checksum of written words: define LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | CPU running, waiting for start_pgm
// LOAD   | accepting bytes, CPU held
// FLUSH  | partial last word written zero-padded
// FINISH | done pulse, CPU still held for one more cycle
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              start_pgm_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              cpu_hold_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              done_o,
  output logic              err_overflow_o,
  output logic [31:0]       checksum_o
);

  logic [1:0]        state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       asm_q, asm_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              cpu_hold_q, cpu_hold_d;

  logic              in_load, timer_clear, expire;
  logic              word_ready, wr_issue, start_load;
  logic [31:0]       word;

  assign in_load     = (state_q == ST_LOAD);
  assign timer_clear = !in_load || rx_valid_i;
  assign start_load  = (state_q == ST_IDLE) && start_pgm_i;

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clock_i (clock_i),
    .reset_ni(reset_ni),
    .clear_i (timer_clear),
    .enable_i(in_load),
    .expire_o(expire)
  );

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    word_ready = 1'b0;
    word       = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_pgm_i) begin
          state_d    = ST_LOAD;
          byte_idx_d = '0;
          asm_d      = '0;
          wr_addr_d  = '0;
          count_d    = '0;
          ovf_d      = 1'b0;
        end
      end
      ST_LOAD: begin
        // A byte arriving on the terminal-count edge beats the timeout.
        if (rx_valid_i) begin
          asm_d      = {asm_q[23:0], rx_data_i};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            word_ready = 1'b1;
            word       = {asm_q[23:0], rx_data_i};
          end
        end else if (expire) begin
          if (byte_idx_q == 2'd0) begin
            state_d = ST_FINISH;
          end else begin
            state_d    = ST_FLUSH;
            byte_idx_d = '0;
            word_ready = 1'b1;
            word       = pad_word(asm_q, byte_idx_q);
          end
        end
      end
      ST_FLUSH: state_d = ST_FINISH;
      default:  state_d = ST_IDLE;
    endcase

    wr_issue = word_ready && !count_q[ADDR_W];
    if (word_ready && count_q[ADDR_W]) begin
      ovf_d = 1'b1;
    end
    if (wr_issue) begin
      wr_en_d   = 1'b1;
      wr_addr_d = count_q[ADDR_W-1:0];
      wr_data_d = word;
      count_d   = count_q + 1'b1;
    end

    done_d     = (state_d == ST_FINISH);
    cpu_hold_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      asm_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start_load)    checksum_d = '0;
    else if (wr_issue) checksum_d = checksum_q + word;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) checksum_q <= '0;
    else           checksum_q <= checksum_d;
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = '0;
`endif

  assign wr_en_o        = wr_en_q;
  assign wr_addr_o      = wr_addr_q;
  assign wr_data_o      = wr_data_q;
  assign cpu_hold_o     = cpu_hold_q;
  assign word_count_o   = count_q;
  assign done_o         = done_q;
  assign err_overflow_o = ovf_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed table, corner sequences and
// random loads compared against a byte-list reference model.
module tb_prog_loader;

  localparam int AW  = 2;
  localparam int TO  = 6;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_pgm = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold;
  logic [AW:0]   word_count;
  logic          done;
  logic          err_overflow;
  logic [31:0]   checksum;

  prog_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clock_i       (clk),
    .reset_ni      (rst_n),
    .start_pgm_i   (start_pgm),
    .rx_data_i     (rx_data),
    .rx_valid_i    (rx_valid),
    .wr_en_o       (wr_en),
    .wr_addr_o     (wr_addr),
    .wr_data_o     (wr_data),
    .cpu_hold_o    (cpu_hold),
    .word_count_o  (word_count),
    .done_o        (done),
    .err_overflow_o(err_overflow),
    .checksum_o    (checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed writes, sampled mid-cycle.
  int          wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];

  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(int'(wr_addr));
      wd_q.push_back(wr_data);
      wc_q.push_back(cyc);
    end
  end

  // Results captured by do_load.
  int          acc_cyc[$];
  int          last_cyc, done_cyc;
  bit          got_done, hold_load_ok, hold_at_done, hold_after, done_after;
  int          cnt_at_done;
  bit          ovf_at_done;
  logic [31:0] sum_at_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_sum(input logic [31:0] s);
`ifdef LOADER_CHECKSUM_EN
    return s;
`else
    return 32'h0;
`endif
  endfunction

  task automatic clear_obs();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); acc_cyc.delete();
  endtask

  // Start a load, send bytes with per-byte trailing gaps, optionally pulse
  // start_pgm alongside byte number pulse_at, then wait (bounded) for done.
  task automatic do_load(input logic [7:0] bq[$], input int gq[$], input int pulse_at);
    int t;
    clear_obs();
    hold_load_ok = 1'b1;
    start_pgm = 1'b1;
    tick();
    start_pgm = 1'b0;
    last_cyc = cyc;
    for (int i = 0; i < bq.size(); i++) begin
      rx_valid  = 1'b1;
      rx_data   = bq[i];
      start_pgm = (i == pulse_at);
      tick();
      acc_cyc.push_back(cyc);
      last_cyc  = cyc;
      if (!cpu_hold) hold_load_ok = 1'b0;
      rx_valid  = 1'b0;
      start_pgm = 1'b0;
      rx_data   = 8'($urandom);
      for (int g = 0; g < gq[i]; g++) tick();
    end
    t = 0;
    while (!done && t < 100) begin
      tick();
      t++;
    end
    got_done     = done;
    done_cyc     = cyc;
    cnt_at_done  = int'(word_count);
    ovf_at_done  = err_overflow;
    sum_at_done  = checksum;
    hold_at_done = cpu_hold;
    tick();
    hold_after   = cpu_hold;
    done_after   = done;
  endtask

  // Reference: group bytes in fours MSB-first, pad the tail, keep the first
  // CAP words, everything else only raises the overflow flag.
  task automatic check_model(input string tag, input logic [7:0] bq[$]);
    int nb, nw, en;
    logic [31:0] w, s;
    nb = bq.size();
    nw = (nb + 3) / 4;
    en = (nw < CAP) ? nw : CAP;
    s  = 32'h0;
    chk({tag, ".done"}, got_done, 1);
    chk({tag, ".nwr"}, wa_q.size(), en);
    for (int k = 0; k < en && k < wa_q.size(); k++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++) w = {w[23:0], (4*k+b < nb) ? bq[4*k+b] : 8'h00};
      s = s + w;
      chk($sformatf("%s.addr%0d", tag, k), wa_q[k], k);
      chk($sformatf("%s.data%0d", tag, k), wd_q[k], w);
      chk($sformatf("%s.wcyc%0d", tag, k), wc_q[k],
          (4*k+3 < nb) ? acc_cyc[4*k+3] : last_cyc + TO);
    end
    chk({tag, ".count"}, cnt_at_done, en);
    chk({tag, ".ovf"}, ovf_at_done, nw > CAP);
    chk({tag, ".sum"}, sum_at_done, exp_sum(s));
    chk({tag, ".lat"}, done_cyc - last_cyc, TO + ((nb % 4) != 0 ? 1 : 0));
    chk({tag, ".hold_load"}, hold_load_ok, 1);
    chk({tag, ".hold_done"}, hold_at_done, 1);
    chk({tag, ".hold_after"}, hold_after, 0);
    chk({tag, ".done_1cyc"}, done_after, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".wr_en"}, wr_en, 0);
    chk({tag, ".wr_addr"}, wr_addr, 0);
    chk({tag, ".wr_data"}, wr_data, 0);
    chk({tag, ".cpu_hold"}, cpu_hold, 1);
    chk({tag, ".count"}, word_count, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".ovf"}, err_overflow, 0);
    chk({tag, ".sum"}, checksum, 0);
  endtask

  typedef struct {
    logic [63:0] data;
    int          n;
    int          gap;
    int          exp_cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] sum;
  } vec_t;

  vec_t        tbl[6];
  logic [7:0]  bq[$];
  int          gq[$];
  int          cnt_before;

  initial begin
    tbl[0] = '{64'h8C01000400000008, 8, 0, 2, 32'h8C010004, 32'h00000008, 32'h8C01000C};
    tbl[1] = '{64'h1122334455660000, 6, 0, 2, 32'h11223344, 32'h55660000, 32'h66883344};
    tbl[2] = '{64'h0,                0, 0, 0, 32'h0,        32'h0,        32'h0};
    tbl[3] = '{64'hFFFFFFFF00000002, 8, 1, 2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    tbl[4] = '{64'hA500000000000000, 1, 5, 1, 32'hA5000000, 32'h0,        32'hA5000000};
    tbl[5] = '{64'h0102030405060700, 7, 5, 2, 32'h01020304, 32'h05060700, 32'h06080A04};

    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel.hold", cpu_hold, 1);
    tick();
    chk("idle.hold", cpu_hold, 0);

    for (int i = 0; i < 6; i++) begin
      bq.delete(); gq.delete();
      for (int k = 0; k < tbl[i].n; k++) begin
        bq.push_back(tbl[i].data[63-8*k -: 8]);
        gq.push_back(tbl[i].gap);
      end
      do_load(bq, gq, -1);
      chk($sformatf("t%0d.done", i), got_done, 1);
      chk($sformatf("t%0d.nwr", i), wa_q.size(), tbl[i].exp_cnt);
      if (tbl[i].exp_cnt > 0 && wa_q.size() > 0) begin
        chk($sformatf("t%0d.a0", i), wa_q[0], 0);
        chk($sformatf("t%0d.d0", i), wd_q[0], tbl[i].w0);
      end
      if (tbl[i].exp_cnt > 1 && wa_q.size() > 1) begin
        chk($sformatf("t%0d.a1", i), wa_q[1], 1);
        chk($sformatf("t%0d.d1", i), wd_q[1], tbl[i].w1);
      end
      chk($sformatf("t%0d.count", i), cnt_at_done, tbl[i].exp_cnt);
      chk($sformatf("t%0d.ovf", i), ovf_at_done, 0);
      chk($sformatf("t%0d.sum", i), sum_at_done, exp_sum(tbl[i].sum));
      chk($sformatf("t%0d.hold_after", i), hold_after, 0);
      check_model($sformatf("t%0d", i), bq);
    end

    // Five words into a four-word memory.
    bq.delete(); gq.delete();
    for (int k = 0; k < 20; k++) begin
      bq.push_back(8'(k * 13 + 1));
      gq.push_back(0);
    end
    do_load(bq, gq, -1);
    chk("ovf.flag", ovf_at_done, 1);
    chk("ovf.count", cnt_at_done, 4);
    chk("ovf.nwr", wa_q.size(), 4);
    check_model("ovf", bq);

    // start_pgm during LOAD is ignored.
    bq.delete(); gq.delete();
    for (int k = 0; k < 8; k++) begin
      bq.push_back(8'(8'h30 + k));
      gq.push_back(0);
    end
    do_load(bq, gq, 6);
    check_model("start_in_load", bq);

    // rx_valid in IDLE is ignored.
    clear_obs();
    cnt_before = int'(word_count);
    for (int k = 0; k < 6; k++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(8'hE0 + k);
      tick();
    end
    rx_valid = 1'b0;
    tick(); tick();
    chk("idle_rx.nwr", wa_q.size(), 0);
    chk("idle_rx.count", word_count, cnt_before);
    chk("idle_rx.hold", cpu_hold, 0);

    // Reset after two bytes of the second word.
    clear_obs();
    start_pgm = 1'b1;
    tick();
    start_pgm = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(8'h90 + k);
      tick();
    end
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    chk("midrst.held_hold", cpu_hold, 1);
    rst_n = 1'b1;
    tick();
    chk("midrst.idle_hold", cpu_hold, 0);
    bq.delete(); gq.delete();
    for (int k = 0; k < 5; k++) begin
      bq.push_back(8'(8'hC0 + k));
      gq.push_back(0);
    end
    do_load(bq, gq, -1);
    check_model("after_rst", bq);

    for (int r = 0; r < 12; r++) begin
      int n;
      bq.delete(); gq.delete();
      n = $urandom_range(0, 22);
      for (int k = 0; k < n; k++) begin
        bq.push_back(8'($urandom));
        gq.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TO - 1)) : 0);
      end
      do_load(bq, gq, int'($urandom_range(0, n + 3)));
      check_model($sformatf("rnd%0d", r), bq);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program-memory writer for the single-cycle MIPS core. It receives a byte stream from the UART receiver and assembles big-endian 32-bit instruction words. Each completed word is written sequentially into the instruction ROM's write port, starting at word address 0. While a load is in progress it holds the CPU (fetch unit and the rest of the datapath) in reset, and it releases the CPU when the stream ends.

## Interface
Parameters:
- ADDR_W, 14, word-address width; matches the fetch unit's PC[15:2] indexing.
- TIMEOUT_CYCLES, 1_000_000, idle cycles without rx_valid that end a load; must be ≥ 2.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_pgm  in  1  one-cycle pulse requesting load mode.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid for exactly this cycle.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word address for wr_data.
- wr_data  out  32  assembled instruction word.
- cpu_hold  out  1  high forces the CPU reset.
- word_count  out  ADDR_W+1  words written in the current or last load.
- done  out  1  one-cycle pulse at the end of a load.
- err_overflow  out  1  sticky; set when a word arrives after memory is full. Cleared by the next start_pgm.
- checksum  out  32  see Configuration.

## Operation
- FSM states: IDLE, LOAD, FLUSH, FINISH.
- IDLE:
  - rx_valid is ignored.
  - start_pgm → LOAD. On entry: byte_idx=0, wr_addr=0, word_count=0, err_overflow=0, checksum=0, timer=0.
- LOAD:
  - cpu_hold=1.
  - Each rx_valid shifts the byte into the assembly register MSB-first: first byte → wr_data[31:24], fourth byte → [7:0]. byte_idx increments mod 4.
  - On the fourth byte, one write is issued.
  - After each write, wr_addr increments and word_count increments.
  - start_pgm is ignored in LOAD.
- Overflow:
  - Once word_count == 2^ADDR_W, further complete words are dropped: no wr_en, and wr_addr saturates at all-ones.
  - err_overflow is set on the first dropped word.
- Timeout:
  - The timer resets on every rx_valid and otherwise increments.
  - When timer == TIMEOUT_CYCLES-1 and byte_idx==0 → FINISH.
  - When byte_idx≠0 → FLUSH.
- FLUSH: remaining low bytes are zero-padded, one write is issued (subject to the overflow rule), then → FINISH.
- FINISH: done=1 for one cycle, cpu_hold stays 1, then → IDLE.
- A load with zero bytes is legal: it times out with word_count=0.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, word_count=0, done=0, err_overflow=0, checksum=0, FSM=IDLE.
  - cpu_hold stays 1 after reset until the first cycle in IDLE following reset deassertion; afterwards it follows the FSM.
- Reset asserted mid-load aborts immediately. Partially written memory is not restored.

## Timing
- wr_en is registered: high in the cycle after the accepting edge of the fourth rx_valid byte. wr_addr and wr_data are stable while wr_en is high.
- Back-to-back rx_valid every cycle is supported. Sustained throughput is one word per 4 cycles.
- FLUSH write occurs the cycle after the timeout edge; FINISH follows one cycle later.
- Release: cpu_hold falls in the cycle after done. The CPU therefore leaves reset with the memory fully written and fetches from PC=0.
- rx_valid on the same edge as the timeout terminal count wins: the byte is accepted and the timer clears.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - checksum holds the 32-bit wrap-around sum of every written word.
  - It updates on the edge that issues wr_en. Dropped overflow words are excluded.
  - Valid from the done pulse until the next start_pgm.
- LOADER_CHECKSUM_EN undefined: checksum is constant 0 and no adder is synthesized.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE, LOAD, FLUSH, FINISH);
  - the default ADDR_W (14), shared with the fetch unit;
  - the default TIMEOUT_CYCLES.
- One sub-module, idle_timer:
  - counts up to TIMEOUT_CYCLES-1 and pulses expire;
  - has clear and enable inputs;
  - uses the same clock and reset.

## Test plan
- Reset, then start_pgm, then bytes 8C,01,00,04,00,00,00,08 at one per cycle, then idle → wr_en at addr 0 data 0x8C010004, then addr 1 data 0x00000008. done after timeout, word_count=2, cpu_hold falls the cycle after done.
- Six bytes 11,22,33,44,55,66 then idle → second write is addr 1 data 0x55660000 via FLUSH. word_count=2.
- ADDR_W=2, 5 words sent → 4 writes to addrs 0–3, err_overflow=1, word_count=4, no fifth wr_en.
- Reset deasserted→asserted after 2 bytes of the second word → all outputs at reset values immediately, and FSM in IDLE after release.
- LOADER_CHECKSUM_EN, words 0xFFFFFFFF and 0x00000002 → checksum=0x00000001 at done.
- rx_valid in IDLE, and start_pgm during LOAD → no write, no state change, no counter reset.
